// File: rtl/controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control unit.
package controller_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BEQ    = 4'd10,
        S_JAL    = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} alu_src_a_t;
    typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_t;
    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_BRANCH = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_t;
    typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEMDATA = 2'b01, RES_ALURESULT = 2'b10} result_src_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_ILLEGAL = 2'b10;

    typedef struct packed {
        logic        pc_write;
        logic        ir_write;
        logic        adr_src;
        alu_src_a_t  alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
        result_src_t result_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
    } ctrl_t;

    function automatic logic is_mem_request(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the instruction register / memory and the multi-cycle datapath.
interface multicycle_controller_if;
    logic [6:0] Opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ResultSrc;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       fault;
    logic [1:0] fault_code;
    logic [3:0] state;

    modport master (
        input  Opcode, mem_ready,
        output PCWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
               RegWrite, MemRead, MemWrite, Branch, fault, fault_code, state
    );

    modport slave (
        output Opcode, mem_ready,
        input  PCWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
               RegWrite, MemRead, MemWrite, Branch, fault, fault_code, state
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive unanswered memory request cycles; expire flags the last allowed one.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expire
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (waiting) begin
            r_count <= r_count + CW'(1);
        end
    end

    // A zero timeout disables the fault path entirely.
    assign expire = (MEM_TIMEOUT != 0) && waiting && (r_count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM: state register, next-state logic and output decode.
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 15,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input logic                     clk,
    input logic                     rst_n,
    multicycle_controller_if.master bus
);
    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_fault_code;
    logic [1:0] w_fault_code;
    ctrl_t      w_ctrl;
    logic       w_waiting;
    logic       w_clear;
    logic       w_expire;

    assign w_waiting = is_mem_request(r_state) && !bus.mem_ready;
    assign w_clear   = (w_next_state != r_state);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_clear),
        .waiting (w_waiting),
        .expire  (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_START;
            r_fault_code <= FC_NONE;
        end else begin
            r_state      <= w_next_state;
            r_fault_code <= w_fault_code;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_fault_code = r_fault_code;
        w_ctrl       = '0;

        case (r_state)
            S_START: w_next_state = S_FETCH;

            S_FETCH: begin
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALURESULT;
                w_ctrl.ir_write   = bus.mem_ready;
                w_ctrl.pc_write   = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next_state = S_DECODE;
                end else if (w_expire) begin
                    w_next_state = S_FAULT;
                    w_fault_code = FC_TIMEOUT;
                end
            end

            S_DECODE: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                case (bus.Opcode)
                    LW, SW: w_next_state = S_MEMADR;
                    R_TYPE: w_next_state = S_EXECR;
                    I_TYPE: w_next_state = S_EXECI;
                    BR:     w_next_state = S_BEQ;
                    JAL:    w_next_state = S_JAL;
                    default: begin
                        if (ILLEGAL_TRAP) begin
                            w_next_state = S_FAULT;
                            w_fault_code = FC_ILLEGAL;
                        end else begin
                            w_next_state = S_FETCH;
                        end
                    end
                endcase
            end

            S_MEMADR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_next_state     = (bus.Opcode == SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD, S_MEMWR: begin
                w_ctrl.adr_src   = 1'b1;
                w_ctrl.mem_read  = (r_state == S_MEMRD);
                w_ctrl.mem_write = (r_state == S_MEMWR);
                if (bus.mem_ready) begin
                    w_next_state = (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (w_expire) begin
                    w_next_state = S_FAULT;
                    w_fault_code = FC_TIMEOUT;
                end
            end

            S_MEMWB: begin
                w_ctrl.result_src = RES_MEMDATA;
                w_ctrl.reg_write  = 1'b1;
                w_next_state      = S_FETCH;
            end

            S_EXECR, S_EXECI: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = (r_state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_next_state     = S_ALUWB;
            end

            S_ALUWB: begin
                w_ctrl.reg_write = 1'b1;
                w_next_state     = S_FETCH;
            end

            S_BEQ: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_op    = ALUOP_BRANCH;
                w_ctrl.branch    = 1'b1;
                w_next_state     = S_FETCH;
            end

            // Link value OldPC+4 is computed here and written back in ALUWB.
            S_JAL: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.pc_write  = 1'b1;
                w_next_state     = S_ALUWB;
            end

            S_FAULT: w_next_state = S_FAULT;

            default: w_next_state = S_START;
        endcase
    end

    assign bus.PCWrite    = w_ctrl.pc_write;
    assign bus.IRWrite    = w_ctrl.ir_write;
    assign bus.AdrSrc     = w_ctrl.adr_src;
    assign bus.ALUSrcA    = w_ctrl.alu_src_a;
    assign bus.ALUSrcB    = w_ctrl.alu_src_b;
    assign bus.ALUOp      = w_ctrl.alu_op;
    assign bus.ResultSrc  = w_ctrl.result_src;
    assign bus.RegWrite   = w_ctrl.reg_write;
    assign bus.MemRead    = w_ctrl.mem_read;
    assign bus.MemWrite   = w_ctrl.mem_write;
    assign bus.Branch     = w_ctrl.branch;
    assign bus.fault      = (r_state == S_FAULT);
    assign bus.fault_code = r_fault_code;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller across three parameter sets.
module tb_multicycle_controller;
    import controller_pkg::*;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       adr;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [1:0] res;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       br;
        logic       flt;
        logic [1:0] fc;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        ctl_t       c;
    } obs_t;

    localparam logic [6:0] ILL = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       rdy;
    logic [1:0] exp_fc;
    obs_t       exp_q[$];
    obs_t       zero_exp;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    multicycle_controller_if if_a ();
    multicycle_controller_if if_b ();
    multicycle_controller_if if_c ();

    assign if_a.Opcode = op;  assign if_a.mem_ready = rdy;
    assign if_b.Opcode = op;  assign if_b.mem_ready = rdy;
    assign if_c.Opcode = op;  assign if_c.mem_ready = rdy;

    multicycle_controller #(.MEM_TIMEOUT(15), .ILLEGAL_TRAP(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    multicycle_controller #(.MEM_TIMEOUT(4),  .ILLEGAL_TRAP(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    multicycle_controller #(.MEM_TIMEOUT(15), .ILLEGAL_TRAP(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    // Expected control word for a state, written straight from the state table.
    function automatic ctl_t model(input state_t s, input logic r, input logic [1:0] fc);
        ctl_t c = '0;
        case (s)
            S_FETCH:  begin c.mr = 1'b1; c.b = 2'b10; c.res = 2'b10; c.irw = r; c.pcw = r; end
            S_DECODE: begin c.a = 2'b01; c.b = 2'b01; end
            S_MEMADR: begin c.a = 2'b10; c.b = 2'b01; end
            S_MEMRD:  begin c.mr = 1'b1; c.adr = 1'b1; end
            S_MEMWB:  begin c.res = 2'b01; c.rw = 1'b1; end
            S_MEMWR:  begin c.mw = 1'b1; c.adr = 1'b1; end
            S_EXECR:  begin c.a = 2'b10; c.b = 2'b00; c.op = 2'b10; end
            S_EXECI:  begin c.a = 2'b10; c.b = 2'b01; c.op = 2'b10; end
            S_ALUWB:  begin c.rw = 1'b1; end
            S_BEQ:    begin c.a = 2'b10; c.op = 2'b01; c.br = 1'b1; end
            S_JAL:    begin c.a = 2'b01; c.b = 2'b10; c.pcw = 1'b1; end
            S_FAULT:  begin c.flt = 1'b1; c.fc = fc; end
            default:  ;
        endcase
        return c;
    endfunction

    function automatic obs_t observe(input int sel);
        obs_t o;
        case (sel)
            0: o = {if_a.state, if_a.PCWrite, if_a.IRWrite, if_a.AdrSrc, if_a.ALUSrcA, if_a.ALUSrcB, if_a.ALUOp,
                    if_a.ResultSrc, if_a.RegWrite, if_a.MemRead, if_a.MemWrite, if_a.Branch, if_a.fault, if_a.fault_code};
            1: o = {if_b.state, if_b.PCWrite, if_b.IRWrite, if_b.AdrSrc, if_b.ALUSrcA, if_b.ALUSrcB, if_b.ALUOp,
                    if_b.ResultSrc, if_b.RegWrite, if_b.MemRead, if_b.MemWrite, if_b.Branch, if_b.fault, if_b.fault_code};
            default: o = {if_c.state, if_c.PCWrite, if_c.IRWrite, if_c.AdrSrc, if_c.ALUSrcA, if_c.ALUSrcB, if_c.ALUOp,
                    if_c.ResultSrc, if_c.RegWrite, if_c.MemRead, if_c.MemWrite, if_c.Branch, if_c.fault, if_c.fault_code};
        endcase
        return o;
    endfunction

    // One clock: drive inputs, push the expectation, compare on the falling edge.
    task automatic step(input int sel, input logic [6:0] o, input logic r, input state_t s, output obs_t got);
        obs_t e;
        op  = o;
        rdy = r;
        exp_q.push_back({s, model(s, r, exp_fc)});
        @(negedge clk);
        got = observe(sel);
        e   = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL step dut=%0d exp_state=%s got=%h exp=%h", sel, s.name(), got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int sel);
        obs_t g;
        rst_n = 1'b0;
        rdy   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                g = observe(k);
                total++;
                if (g !== zero_exp) begin
                    bad++;
                    $display("FAIL in_reset dut=%0d got=%h exp=%h", k, g, zero_exp);
                end
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(sel, op, 1'b1, S_START, g);
    endtask

    task automatic test_reset();
        do_reset(0);
    endtask

    task automatic test_lw();
        obs_t g;
        int   rw_cnt = 0;
        state_t seq[5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
        for (int i = 0; i < 5; i++) begin
            step(0, LW, 1'b1, seq[i], g);
            if (g.c.rw) rw_cnt++;
        end
        total++;
        if (rw_cnt !== 1) begin bad++; $display("FAIL lw_regwrite_cycles got=%0d exp=1", rw_cnt); end
    endtask

    task automatic test_sw_wait();
        obs_t g;
        int   mw_cnt = 0;
        int   adr_cnt = 0;
        step(0, SW, 1'b1, S_FETCH, g);
        step(0, SW, 1'b1, S_DECODE, g);
        step(0, SW, 1'b1, S_MEMADR, g);
        for (int i = 0; i < 4; i++) begin
            step(0, SW, (i == 3), S_MEMWR, g);
            if (g.c.mw) mw_cnt++;
            if (g.c.adr) adr_cnt++;
        end
        total++;
        if (mw_cnt !== 4 || adr_cnt !== 4) begin
            bad++;
            $display("FAIL sw_wait_request got=%0d/%0d exp=4/4", mw_cnt, adr_cnt);
        end
        step(0, SW, 1'b1, S_FETCH, g);
        step(0, SW, 1'b1, S_DECODE, g);
        step(0, SW, 1'b1, S_MEMADR, g);
        step(0, SW, 1'b1, S_MEMWR, g);
    endtask

    task automatic test_alu();
        obs_t g;
        step(0, R_TYPE, 1'b1, S_FETCH, g);
        step(0, R_TYPE, 1'b1, S_DECODE, g);
        step(0, R_TYPE, 1'b1, S_EXECR, g);
        step(0, R_TYPE, 1'b1, S_ALUWB, g);
        step(0, I_TYPE, 1'b1, S_FETCH, g);
        step(0, I_TYPE, 1'b1, S_DECODE, g);
        step(0, I_TYPE, 1'b1, S_EXECI, g);
        step(0, I_TYPE, 1'b1, S_ALUWB, g);
    endtask

    task automatic test_fetch_wait();
        obs_t g;
        step(0, R_TYPE, 1'b0, S_FETCH, g);
        step(0, R_TYPE, 1'b0, S_FETCH, g);
        step(0, R_TYPE, 1'b1, S_FETCH, g);
        step(0, R_TYPE, 1'b1, S_DECODE, g);
        step(0, R_TYPE, 1'b1, S_EXECR, g);
        step(0, R_TYPE, 1'b1, S_ALUWB, g);
    endtask

    task automatic test_branch_jal();
        obs_t g;
        int   br_cnt = 0;
        state_t seq[3] = '{S_FETCH, S_DECODE, S_BEQ};
        for (int i = 0; i < 3; i++) begin
            step(0, BR, 1'b1, seq[i], g);
            if (g.c.br) br_cnt++;
        end
        step(0, JAL, 1'b1, S_FETCH, g);
        if (g.c.br) br_cnt++;
        total++;
        if (br_cnt !== 1) begin bad++; $display("FAIL beq_branch_cycles got=%0d exp=1", br_cnt); end
        step(0, JAL, 1'b1, S_DECODE, g);
        step(0, JAL, 1'b1, S_JAL, g);
        step(0, JAL, 1'b1, S_ALUWB, g);
    endtask

    task automatic test_illegal();
        obs_t g;
        step(2, ILL, 1'b1, S_FETCH, g);
        step(2, ILL, 1'b1, S_DECODE, g);
        step(2, ILL, 1'b1, S_FETCH, g);
        do_reset(0);
        step(0, ILL, 1'b1, S_FETCH, g);
        step(0, ILL, 1'b1, S_DECODE, g);
        exp_fc = 2'b10;
        step(0, LW, 1'b1, S_FAULT, g);
        step(0, LW, 1'b0, S_FAULT, g);
        step(0, R_TYPE, 1'b1, S_FAULT, g);
        exp_fc = 2'b00;
        do_reset(1);
    endtask

    task automatic test_timeout();
        obs_t g;
        for (int i = 0; i < 4; i++) step(1, R_TYPE, 1'b0, S_FETCH, g);
        exp_fc = 2'b01;
        step(1, R_TYPE, 1'b1, S_FAULT, g);
        step(1, R_TYPE, 1'b1, S_FAULT, g);
        step(1, R_TYPE, 1'b0, S_FAULT, g);
        exp_fc = 2'b00;
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1, R_TYPE, 1'b0, S_FETCH, g);
        step(1, R_TYPE, 1'b1, S_FETCH, g);
        step(1, R_TYPE, 1'b1, S_DECODE, g);
        step(1, R_TYPE, 1'b1, S_EXECR, g);
        step(1, R_TYPE, 1'b1, S_ALUWB, g);
    endtask

    task automatic test_reset_abort();
        obs_t g;
        step(0, LW, 1'b1, S_FETCH, g);
        step(0, LW, 1'b1, S_DECODE, g);
        step(0, LW, 1'b1, S_MEMADR, g);
        rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        g = observe(0);
        total++;
        if (g !== zero_exp) begin bad++; $display("FAIL abort_memrd got=%h exp=%h", g, zero_exp); end
        do_reset(0);
    endtask

    initial begin
        rst_n    = 1'b0;
        op       = LW;
        rdy      = 1'b1;
        exp_fc   = 2'b00;
        zero_exp = {S_START, 18'h0};
        @(posedge clk);
        #1;
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu();
        test_fetch_wait();
        test_branch_jal();
        test_illegal();
        test_timeout();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle main control unit for the RV32I subset core, successor to the single-cycle decoder. Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and adds JAL support. Memory accesses use a ready handshake with wait-state tolerance and a bounded timeout. Illegal opcodes and memory timeouts raise a sticky fault. Sits between the instruction register (Opcode) and the shared-memory multi-cycle datapath.

## Interface
- MEM_TIMEOUT, 15: max consecutive unanswered request cycles before fault; 0 disables timeout.
- ILLEGAL_TRAP, 1: 1 = unknown opcode enters FAULT; 0 = unknown opcode is skipped (back to FETCH).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- Opcode  in  7  instr[6:0] from the latched instruction register.
- mem_ready  in  1  memory acknowledge for the current MemRead/MemWrite request.
- PCWrite  out  1  unconditional PC load.
- IRWrite  out  1  instruction register load.
- AdrSrc  out  1  memory address: 0 PC, 1 ALUOut.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1.
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
- ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded.
- ResultSrc  out  2  00 ALUOut, 01 MemData, 10 ALUResult.
- RegWrite, MemRead, MemWrite, Branch  out  1 each  as in the single-cycle controller; the datapath loads PC on PCWrite | (Branch & Zero).
- fault  out  1  sticky error flag.
- fault_code  out  2  00 none, 01 mem timeout, 10 illegal opcode.
- state  out  4  current state encoding (debug).

## Operation
- States: START, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL, FAULT.
- Every control output not listed for a state is 0.
- START: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite equal mem_ready (Mealy).
  - On mem_ready, go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - Other → FAULT with code 10 if ILLEGAL_TRAP, else FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. LW → MEMRD, SW → MEMWR.
- MEMRD: MemRead=1, AdrSrc=1. On mem_ready, go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state is FETCH.
- MEMWR: MemWrite=1, AdrSrc=1. On mem_ready, go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state is FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next state is ALUWB, which writes rd=OldPC+4.
- FAULT: all control enables 0; fault=1; fault_code held. Only reset exits.
- Wait counter, width $clog2(MEM_TIMEOUT+1):
  - Cleared on any state change.
  - Increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0.
  - When the counter equals MEM_TIMEOUT-1 and mem_ready=0, the next state is FAULT with code 01.
  - mem_ready in the same cycle as the timeout condition wins: normal transition, no fault.

## Timing
- Reset (asynchronous): state=START, counter=0, fault=0, fault_code=00, all outputs 0 while rst_n is low.
- Reset asserted mid-instruction aborts it immediately; no partial write is held.
- Latency with zero wait states (mem_ready held 1), START excluded:
  - LW 5 cycles, SW 4.
  - R-type and I-type 4.
  - BEQ 3, JAL 4.
- Each memory wait cycle adds 1 cycle to the state it occurs in.
- Request signals (MemRead/MemWrite) and AdrSrc stay stable from request entry until the mem_ready cycle.
- All state, counter and fault registers update on the rising clk edge only.
- Outputs are combinational from state; the exception is FETCH IRWrite/PCWrite, which also depend on mem_ready.

## Structure
- controller_pkg holds:
  - opcode constants (R_TYPE, I_TYPE, LW, SW, BR, JAL);
  - state_t enum (4-bit);
  - ALUSrcA/ALUSrcB/ResultSrc/ALUOp encodings;
  - fault_code constants.
- Sub-module mem_wait_timer, parameter MEM_TIMEOUT:
  - inputs: clk, rst_n, clear, waiting;
  - output: expire.
- The top is the state register, the next-state logic and the output decode.

## Test plan
- Reset: hold rst_n=0 three cycles, then release → state=START for 1 cycle, then FETCH with MemRead=1; all outputs 0 during reset.
- LW with mem_ready held 1, Opcode=0000011 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 and ResultSrc=01 only in MEMWB.
- SW with 3 wait states in MEMWR → MemWrite=1 for 4 cycles, AdrSrc=1 throughout, no fault, return to FETCH.
- Timeout: MEM_TIMEOUT=4, mem_ready=0 in FETCH → FAULT after 4 request cycles, fault_code=01, all enables 0 until reset.
  - Repeat with mem_ready=1 in the 4th cycle → DECODE, no fault.
- Illegal opcode 1111111: with ILLEGAL_TRAP=1 → FAULT, fault_code=10; with ILLEGAL_TRAP=0 → FETCH, fault=0.
- JAL (1101111) and BEQ (1100011) → JAL asserts PCWrite=1 then ALUWB RegWrite=1; BEQ asserts Branch=1 and ALUOp=01 for exactly 1 cycle.
